countdown_timer: RTL and testbench

Loadable, prescaled down-counter. The decrementing counterpart to the free-running up-counter. Software or a controlling FSM loads a start value, starts it, and receives a one-cycle `done` pulse when the count reaches zero. An optional auto-reload mode turns it into a periodic tick generator for timeouts and pacing elsewhere in the design.

---
 rtl/countdown_timer_if.sv | 24 ++
 rtl/countdown_timer.sv | 94 +++++++++
 tb/tb_countdown_timer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: load/start/pause/auto-reload
// requests from the controller, and count/done/busy status back from the timer.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             busy;

  modport master (
    output load, load_value, start, pause, auto_reload,
    input  out, done, busy
  );

  modport slave (
    input  load, load_value, start, pause, auto_reload,
    output out, done, busy
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with a one-cycle done pulse on reaching zero
// and an optional auto-reload mode for periodic ticks.
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic            clock,
  input  logic            reset,
  countdown_timer_if.slave tmr
);

  localparam int PW = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (tmr.load) begin
      out_d    = tmr.load_value;
      reload_d = tmr.load_value;
      presc_d  = '0;
      state_d  = IDLE;
    end else if (state_q == IDLE) begin
      if (tmr.start) begin
        if (out_q != '0) begin
          state_d = RUNNING;
          presc_d = '0;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (tmr.pause) begin
      state_d = PAUSED;
    end else begin
      // The resume cycle out of PAUSED counts, so each paused clock costs exactly one clock.
      state_d = RUNNING;
      if (presc_q != PRESC_MAX) begin
        presc_d = presc_q + 1'b1;
      end else begin
        presc_d = '0;
        if (out_q > WIDTH'(1)) begin
          out_d = out_q - 1'b1;
        end else if (out_q == WIDTH'(1)) begin
          out_d  = '0;
          done_d = 1'b1;
          if (!tmr.auto_reload) begin
            state_d = IDLE;
          end
        end else if (reload_q != '0) begin
          out_d = reload_q;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  assign tmr.out  = out_q;
  assign tmr.done = done_q;
  assign tmr.busy = (state_q != IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes per-cycle expectations,
// independent monitors pop and compare them for a PRESCALE=1 and a PRESCALE=4 instance.
module tb_countdown_timer;

  typedef struct {
    logic [3:0] out;
    logic       done;
    logic       busy;
    string      tag;
  } exp_t;

  logic clock;
  logic reset;
  int   assertCount;
  int   failCount;
  exp_t q1[$];
  exp_t q4[$];

  countdown_timer_if #(.WIDTH(4)) if1 ();
  countdown_timer_if #(.WIDTH(4)) if4 ();

  countdown_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .tmr   (if1.slave)
  );

  countdown_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .tmr   (if4.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue what the outputs must be after the next rising edge.
  task automatic applyStimulus(input int d, input logic rst, input logic ld, input logic [3:0] lv,
                               input logic st, input logic pa, input logic ar,
                               input logic [3:0] eo, input logic ed, input logic eb, input string tag);
    exp_t e;
    @(negedge clock);
    reset = rst;
    if1.load = 1'b0; if1.load_value = 4'd0; if1.start = 1'b0; if1.pause = 1'b0; if1.auto_reload = 1'b0;
    if4.load = 1'b0; if4.load_value = 4'd0; if4.start = 1'b0; if4.pause = 1'b0; if4.auto_reload = 1'b0;
    e = '{out: eo, done: ed, busy: eb, tag: tag};
    if (d == 1) begin
      if1.load = ld; if1.load_value = lv; if1.start = st; if1.pause = pa; if1.auto_reload = ar;
      q1.push_back(e);
    end else begin
      if4.load = ld; if4.load_value = lv; if4.start = st; if4.pause = pa; if4.auto_reload = ar;
      q4.push_back(e);
    end
  endtask

  task automatic s1(input logic ld, input logic [3:0] lv, input logic st, input logic pa, input logic ar,
                    input logic [3:0] eo, input logic ed, input logic eb, input string tag);
    applyStimulus(1, 1'b0, ld, lv, st, pa, ar, eo, ed, eb, tag);
  endtask

  task automatic s4(input logic ld, input logic [3:0] lv, input logic st, input logic pa, input logic ar,
                    input logic [3:0] eo, input logic ed, input logic eb, input string tag);
    applyStimulus(4, 1'b0, ld, lv, st, pa, ar, eo, ed, eb, tag);
  endtask

  initial begin : mon1
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q1.size() != 0) begin
        e = q1.pop_front();
        checkOutput({"p1.", e.tag, ".out"},  {4'd0, if1.out},  {4'd0, e.out});
        checkOutput({"p1.", e.tag, ".done"}, {7'd0, if1.done}, {7'd0, e.done});
        checkOutput({"p1.", e.tag, ".busy"}, {7'd0, if1.busy}, {7'd0, e.busy});
      end
    end
  end

  initial begin : mon4
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q4.size() != 0) begin
        e = q4.pop_front();
        checkOutput({"p4.", e.tag, ".out"},  {4'd0, if4.out},  {4'd0, e.out});
        checkOutput({"p4.", e.tag, ".done"}, {7'd0, if4.done}, {7'd0, e.done});
        checkOutput({"p4.", e.tag, ".busy"}, {7'd0, if4.busy}, {7'd0, e.busy});
      end
    end
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    if1.load = 1'b0; if1.load_value = 4'd0; if1.start = 1'b0; if1.pause = 1'b0; if1.auto_reload = 1'b0;
    if4.load = 1'b0; if4.load_value = 4'd0; if4.start = 1'b0; if4.pause = 1'b0; if4.auto_reload = 1'b0;

    applyStimulus(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "reset");
    applyStimulus(4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "reset");

    // Reset in the middle of a count
    s1(1, 4'd9, 0, 0, 0, 4'd9, 0, 0, "rmid_load");
    s1(0, 4'd0, 1, 0, 0, 4'd9, 0, 1, "rmid_start");
    s1(0, 4'd0, 0, 0, 0, 4'd8, 0, 1, "rmid_8");
    s1(0, 4'd0, 0, 0, 0, 4'd7, 0, 1, "rmid_7");
    s1(0, 4'd0, 0, 0, 0, 4'd6, 0, 1, "rmid_6");
    s1(0, 4'd0, 0, 0, 0, 4'd5, 0, 1, "rmid_5");
    applyStimulus(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "rmid_reset");
    for (int i = 0; i < 3; i++) s1(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "rmid_after");

    // One-shot from 3
    s1(1, 4'd3, 0, 0, 0, 4'd3, 0, 0, "os_load");
    s1(0, 4'd0, 1, 0, 0, 4'd3, 0, 1, "os_start");
    s1(0, 4'd0, 0, 0, 0, 4'd2, 0, 1, "os_2");
    s1(0, 4'd0, 0, 0, 0, 4'd1, 0, 1, "os_1");
    s1(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, "os_done");
    s1(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "os_after");

    // Auto-reload from 2, then drop auto_reload
    s1(1, 4'd2, 0, 0, 1, 4'd2, 0, 0, "ar_load");
    s1(0, 4'd0, 1, 0, 1, 4'd2, 0, 1, "ar_start");
    for (int i = 0; i < 3; i++) begin
      s1(0, 4'd0, 0, 0, 1, 4'd1, 0, 1, "ar_1");
      s1(0, 4'd0, 0, 0, 1, 4'd0, 1, 1, "ar_0");
      s1(0, 4'd0, 0, 0, 1, 4'd2, 0, 1, "ar_reload");
    end
    s1(0, 4'd0, 0, 0, 0, 4'd1, 0, 1, "ar_drop_1");
    s1(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, "ar_drop_done");
    s1(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "ar_drop_idle");

    // Start with a zero count: single done, never busy
    s1(0, 4'd0, 1, 0, 0, 4'd0, 1, 0, "zero_start");
    s1(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "zero_after");

    // Load and start together: load wins
    s1(1, 4'd5, 1, 0, 0, 4'd5, 0, 0, "ldst_both");
    s1(0, 4'd0, 0, 0, 0, 4'd5, 0, 0, "ldst_idle");

    // Load while running aborts the count
    s1(0, 4'd0, 1, 0, 0, 4'd5, 0, 1, "abort_start");
    s1(0, 4'd0, 0, 0, 0, 4'd4, 0, 1, "abort_4");
    s1(0, 4'd0, 0, 0, 0, 4'd3, 0, 1, "abort_3");
    s1(0, 4'd0, 0, 0, 0, 4'd2, 0, 1, "abort_2");
    s1(1, 4'd7, 0, 0, 0, 4'd7, 0, 0, "abort_load7");
    s1(0, 4'd0, 0, 0, 0, 4'd7, 0, 0, "abort_hold");
    s1(0, 4'd0, 0, 0, 0, 4'd7, 0, 0, "abort_hold");

    // Full range one-shot from 15: no wrap after zero
    s1(1, 4'd15, 0, 0, 0, 4'd15, 0, 0, "full_load");
    s1(0, 4'd0, 1, 0, 0, 4'd15, 0, 1, "full_start");
    for (int v = 14; v >= 1; v--) s1(0, 4'd0, 0, 0, 0, 4'(v), 0, 1, "full_dec");
    s1(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, "full_done");
    s1(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "full_nowrap");
    s1(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "full_nowrap");

    // PRESCALE=4, load 2, three paused clocks: done 11 clocks after start
    s4(1, 4'd2, 0, 0, 0, 4'd2, 0, 0, "ps_load");
    s4(0, 4'd0, 1, 0, 0, 4'd2, 0, 1, "ps_start");
    s4(0, 4'd0, 0, 0, 0, 4'd2, 0, 1, "ps_c1");
    for (int i = 0; i < 3; i++) s4(0, 4'd0, 0, 1, 0, 4'd2, 0, 1, "ps_paused");
    s4(0, 4'd0, 0, 0, 0, 4'd2, 0, 1, "ps_c5");
    s4(0, 4'd0, 0, 0, 0, 4'd2, 0, 1, "ps_c6");
    s4(0, 4'd0, 0, 0, 0, 4'd1, 0, 1, "ps_c7");
    for (int i = 0; i < 3; i++) s4(0, 4'd0, 0, 0, 0, 4'd1, 0, 1, "ps_win2");
    s4(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, "ps_done");
    s4(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "ps_after");

    for (int i = 0; i < 10 && (q1.size() != 0 || q4.size() != 0); i++) begin
      @(posedge clock);
      #2;
    end
    if (q1.size() != 0 || q4.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", q1.size() + q4.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
